// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: bundle geometry and the two-instruction bundle layout.
package fetch_pkg;

  localparam int BUNDLE_W = 128;
  localparam int INSTR_W  = 32;
  localparam int PC_W     = 32;

  localparam int PC0_LSB    = 0;
  localparam int INSTR0_LSB = 32;
  localparam int PC1_LSB    = 64;
  localparam int INSTR1_LSB = 96;

  typedef struct packed {
    logic [INSTR_W-1:0] instr1;
    logic [PC_W-1:0]    pc1;
    logic [INSTR_W-1:0] instr0;
    logic [PC_W-1:0]    pc0;
  } fetch_bundle_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Bundle storage array: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// In-order bundle queue between fetch and decode with registered skid backpressure and
// flush on accepted jump. Full/empty is tracked by an occupancy counter, not pointer compare.
module instr_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int SKID  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [BUNDLE_W-1:0]      fetch_instr_pc,
  input  logic                     write_fifo,
  input  logic                     jump_accept,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [BUNDLE_W-1:0]      dec_bundle,
  output logic                     stop_fetch,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] STOP_CNT = CW'(DEPTH - SKID);

  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       wr_ptr;
  logic                rd;
  logic                wr;
  logic                drop;
  logic                mem_we;
  logic [CW-1:0]       count_next;
  logic [BUNDLE_W-1:0] rdata;

  assign dec_valid = (count != '0);
  assign dec_bundle = dec_valid ? rdata : '0;

  // A write into a full queue only survives if the head leaves on the same edge.
  always_comb begin
    rd         = dec_valid && dec_ready;
    wr         = write_fifo && ((count < FULL_CNT) || rd);
    drop       = write_fifo && (count == FULL_CNT) && !rd;
    count_next = count + CW'(wr) - CW'(rd);
    mem_we     = wr && rst_n && !jump_accept;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      stop_fetch   <= 1'b0;
      overflow_err <= 1'b0;
    end else if (jump_accept) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      stop_fetch <= 1'b0;
    end else begin
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      count      <= count_next;
      stop_fetch <= (count_next >= STOP_CNT);
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BUNDLE_W),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (fetch_instr_pc),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Bundle queue between the fetch stage and decode.
- Buffers 128-bit two-instruction bundles written by fetch (fetch_instr_pc / write_fifo) and presents them in order to decode with a valid/ready handshake.
- Drives stop_fetch back to fetch as registered backpressure, with skid room for in-flight bundles.
- Flushes all contents when a jump is accepted.

Parameters:
- DEPTH, 8, number of bundle entries; power of 2, minimum 4.
- SKID, 2, free entries still remaining when stop_fetch asserts; covers fetch-side latency; must be less than DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- fetch_instr_pc  input  128  bundle: [127:96] instr1, [95:64] pc1, [63:32] instr0, [31:0] pc0.
- write_fifo  input  1  fetch_instr_pc valid this cycle.
- jump_accept  input  1  redirect accepted; flush the queue.
- dec_ready  input  1  decode consumes the head bundle this cycle.
- dec_valid  output  1  head bundle present.
- dec_bundle  output  128  head bundle; all-zero when dec_valid=0.
- stop_fetch  output  1  registered backpressure to fetch.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow_err  output  1  sticky: a write was dropped because the queue was full.

Behaviour:
- Reset (rst_n=0 at a clk edge): rd_ptr=wr_ptr=0, count=0, stop_fetch=0, overflow_err=0. As a result dec_valid=0 and dec_bundle=0. Storage contents are don't-care.
- Reset applied mid-operation discards all entries; it has priority over every other input.
- Read fire: rd = dec_valid && dec_ready. Pops the head; rd_ptr increments modulo DEPTH.
- Write fire: wr = write_fifo && (count<DEPTH || rd). Stores at wr_ptr; wr_ptr increments modulo DEPTH.
  - A write with write_fifo=1, count=DEPTH and no read is dropped and sets overflow_err (sticky until reset).
- Latency: a bundle written at edge N is visible on dec_valid/dec_bundle after edge N. There is no same-cycle bypass, so an empty queue shows dec_valid=0 even when write_fifo=1.
- Count update:
  - count_next = count + wr - rd.
  - A simultaneous read and write leaves count unchanged.
  - At full with simultaneous read and write: the write is accepted and count stays DEPTH.
- dec_valid = (count != 0), combinational from registered state. dec_bundle = mem[rd_ptr] gated by dec_valid.
- Flush (jump_accept=1 at an edge):
  - Sets rd_ptr=wr_ptr=0 and count=0.
  - Any same-cycle write or read is ignored; the flush has priority.
  - stop_fetch is cleared on the same edge.
  - overflow_err is unaffected.
- stop_fetch:
  - Registered: stop_fetch <= (count_next >= DEPTH-SKID), evaluated with flush and reset taking priority.
  - Fetch honours it one cycle late. With SKID >= 2, correct fetch behaviour therefore never causes an overflow.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full versus empty is resolved by count, not by pointer comparison.
- No combinational path from write_fifo or fetch_instr_pc to any output.

Decomposition:
- Shared package fetch_pkg holds:
  - Constants: BUNDLE_W=128, INSTR_W=32, PC_W=32.
  - Field offsets: PC0_LSB=0, INSTR0_LSB=32, PC1_LSB=64, INSTR1_LSB=96.
  - Packed typedef fetch_bundle_t {instr1, pc1, instr0, pc0}.
- One natural sub-module: sync_fifo_mem, a DEPTH x 128 storage array with write port (we, waddr, wdata) and asynchronous read (raddr, rdata), with no reset on the array. Pointer, count and control logic stay in instr_queue.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles with write_fifo=1 -> count=0, dec_valid=0, dec_bundle=0, stop_fetch=0 throughout reset. After release, the first bundle is visible one cycle after its write edge.
- Fill with dec_ready=0: write bundles with pc0=0x0,0x8,0x10,… -> stop_fetch rises on the edge where count reaches 6 (DEPTH=8, SKID=2). count saturates at 8. A 9th write sets overflow_err=1 and count stays 8.
- Full simultaneous read/write: at count=8, set write_fifo=1 and dec_ready=1 -> count stays 8, overflow_err stays 0, and the head advances to the next-oldest bundle.
- Wrap-around ordering: stream 20 bundles (pc0=0x100+8k) with dec_ready toggling 1/0 -> decode receives pc0 strictly increasing by 8, with no loss or duplication after the pointers wrap twice.
- Flush: at count=5, assert jump_accept together with write_fifo=1 and dec_ready=1 -> count=0, dec_valid=0, stop_fetch=0 next cycle, and the concurrent bundle is not stored.
- Reset mid-stream: rst_n=0 for one edge at count=4 with stop_fetch=0 -> all state clears, including overflow_err. A subsequent write of pc0=0x200 is the first bundle delivered.
